// File: rtl/mdio_sched_if.sv
// Bus bundles around the MDIO command scheduler: the host register port and
// the request port into the MDIO engine.

interface mdio_host_if;
  logic        h_valid;
  logic        h_write;
  logic [4:0]  h_addr;
  logic [15:0] h_wdata;
  logic        h_ready;
  logic        h_rvalid;
  logic [15:0] h_rdata;
  logic        h_err;

  modport master (
    output h_valid, h_write, h_addr, h_wdata,
    input  h_ready, h_rvalid, h_rdata, h_err
  );
  modport slave (
    input  h_valid, h_write, h_addr, h_wdata,
    output h_ready, h_rvalid, h_rdata, h_err
  );
endinterface

interface mdio_req_if;
  logic        m_valid;
  logic        m_write;
  logic [4:0]  m_addr;
  logic [15:0] m_wdata;
  logic        m_done;
  logic [15:0] m_rdata;

  modport master (
    output m_valid, m_write, m_addr, m_wdata,
    input  m_done, m_rdata
  );
  modport slave (
    input  m_valid, m_write, m_addr, m_wdata,
    output m_done, m_rdata
  );
endinterface

// File: rtl/mdio_sched.sv
// MDIO command scheduler: replays a PHY init write table after reset, then
// shares the MDIO engine between a periodic link poller and a host port.

module mdio_sched #(
  parameter int unsigned             INIT_LEN    = 4,
  parameter logic [21*INIT_LEN-1:0]  INIT_TABLE  = '0,
  parameter int unsigned             POLL_PERIOD = 2_500_000,
  parameter logic [4:0]              STATUS_REG  = 5'd1,
  parameter int unsigned             LINK_BIT    = 2,
  parameter int unsigned             TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  mdio_host_if.slave  host,
  mdio_req_if.master  mdio,
  output logic        init_done,
  output logic        init_err,
  output logic        link_up,
  output logic        link_chg
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_POLL, SRC_HOST} src_t;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = $clog2(POLL_PERIOD + 1);

  state_t         state, state_nxt;
  src_t           src, src_sel;
  logic [4:0]     idx;
  logic [TW-1:0]  tcnt;
  logic [PW-1:0]  poll_cnt;
  logic           poll_pend;
  logic           poll_wrap, pend_any, timed_out, issue_end, start;
  logic [20:0]    init_entry;

  assign init_entry = INIT_TABLE[21*int'(idx) +: 21];
  // A wrap in the current cycle already counts as pending, so the poll beats a
  // host request arriving in the same IDLE cycle.
  assign poll_wrap  = init_done && (poll_cnt == PW'(POLL_PERIOD - 1));
  assign pend_any   = poll_pend || poll_wrap;
  assign timed_out  = (tcnt == TW'(TIMEOUT - 1));
  assign issue_end  = (state == ISSUE) && (mdio.m_done || timed_out);
  assign start      = (state == IDLE) && (state_nxt == ISSUE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    src_sel   = SRC_HOST;
    case (state)
      IDLE: begin
        if (!init_done) begin
          state_nxt = ISSUE;
          src_sel   = SRC_INIT;
        end else if (pend_any) begin
          state_nxt = ISSUE;
          src_sel   = SRC_POLL;
        end else if (host.h_valid) begin
          state_nxt = ISSUE;
          src_sel   = SRC_HOST;
        end
      end
      ISSUE:   if (issue_end) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mdio.m_valid = (state == ISSUE);
    host.h_ready = (state == IDLE) && init_done && !pend_any;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src          <= SRC_INIT;
      idx          <= '0;
      tcnt         <= '0;
      poll_cnt     <= '0;
      poll_pend    <= 1'b0;
      init_done    <= 1'b0;
      init_err     <= 1'b0;
      link_up      <= 1'b0;
      link_chg     <= 1'b0;
      mdio.m_write <= 1'b0;
      mdio.m_addr  <= '0;
      mdio.m_wdata <= '0;
      host.h_rvalid <= 1'b0;
      host.h_rdata  <= '0;
      host.h_err    <= 1'b0;
    end else begin
      link_chg      <= 1'b0;
      host.h_rvalid <= 1'b0;
      tcnt          <= (state == ISSUE) ? tcnt + 1'b1 : '0;

      if (init_done) poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
      if (start && src_sel == SRC_POLL) poll_pend <= 1'b0;
      else if (poll_wrap)               poll_pend <= 1'b1;

      // Request fields are latched once and held through ISSUE, GAP and IDLE.
      if (start) begin
        src <= src_sel;
        case (src_sel)
          SRC_INIT: begin
            mdio.m_write <= 1'b1;
            mdio.m_addr  <= init_entry[20:16];
            mdio.m_wdata <= init_entry[15:0];
          end
          SRC_POLL: begin
            mdio.m_write <= 1'b0;
            mdio.m_addr  <= STATUS_REG;
            mdio.m_wdata <= '0;
          end
          default: begin
            mdio.m_write <= host.h_write;
            mdio.m_addr  <= host.h_addr;
            mdio.m_wdata <= host.h_wdata;
          end
        endcase
      end

      if (issue_end) begin
        case (src)
          SRC_INIT: begin
            idx <= idx + 1'b1;
            if (!mdio.m_done) init_err <= 1'b1;
          end
          SRC_POLL: begin
            if (mdio.m_done) begin
              link_up  <= mdio.m_rdata[LINK_BIT];
              link_chg <= mdio.m_rdata[LINK_BIT] != link_up;
            end
          end
          default: begin
            host.h_rvalid <= 1'b1;
            host.h_err    <= !mdio.m_done;
            host.h_rdata  <= (mdio.m_done && !mdio.m_write) ? mdio.m_rdata : '0;
          end
        endcase
      end

      if (state == GAP && src == SRC_INIT && idx == 5'(INIT_LEN)) init_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mdio_sched.sv
// Directed bench for mdio_sched: init replay, link polling, poll/host
// arbitration, host transactions, timeouts and mid-transaction reset.

module tb_mdio_sched;

  localparam logic [62:0] TABLE = {21'h0401E1, 21'h1B0010, 21'h008000};

  logic clk = 1'b0;
  logic reset;
  logic init_done, init_err, link_up, link_chg;

  always #5 clk = ~clk;

  mdio_host_if hb ();
  mdio_req_if  mb ();

  mdio_sched #(
    .INIT_LEN(3), .INIT_TABLE(TABLE), .POLL_PERIOD(200),
    .STATUS_REG(5'd1), .LINK_BIT(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .host(hb), .mdio(mb),
    .init_done(init_done), .init_err(init_err),
    .link_up(link_up), .link_chg(link_chg)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] status_val = 16'h0004;
  logic [5:0]  drop_addr  = 6'h3F;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // PHY model: answers 40 cycles after each m_valid rise unless the address is dropped.
  initial begin
    logic [15:0] regs [32];
    int   age;
    logic active;
    for (int i = 0; i < 32; i++) regs[i] = 16'h0000;
    regs[2]     = 16'h0141;
    age         = 0;
    active      = 1'b0;
    mb.m_done   = 1'b0;
    mb.m_rdata  = 16'hDEAD;
    forever begin
      @(negedge clk);
      mb.m_done  = 1'b0;
      mb.m_rdata = 16'hDEAD;
      if (mb.m_valid !== 1'b1) active = 1'b0;
      else begin
        if (!active) begin
          active = 1'b1;
          age    = 0;
        end else age++;
        if (age == 40 && {1'b0, mb.m_addr} != drop_addr) begin
          mb.m_done = 1'b1;
          if (mb.m_write) regs[mb.m_addr] = mb.m_wdata;
          else mb.m_rdata = (mb.m_addr == 5'd1) ? status_val : regs[mb.m_addr];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1);
  end

  task automatic check_reset_state();
    check("rst_m_valid",   mb.m_valid,   0);
    check("rst_m_write",   mb.m_write,   0);
    check("rst_m_addr",    mb.m_addr,    0);
    check("rst_m_wdata",   mb.m_wdata,   0);
    check("rst_h_ready",   hb.h_ready,   0);
    check("rst_h_rvalid",  hb.h_rvalid,  0);
    check("rst_h_err",     hb.h_err,     0);
    check("rst_h_rdata",   hb.h_rdata,   0);
    check("rst_init_done", init_done,    0);
    check("rst_init_err",  init_err,     0);
    check("rst_link_up",   link_up,      0);
    check("rst_link_chg",  link_chg,     0);
  endtask

  task automatic wait_rise(input string name, input int limit);
    int n = 0;
    while (mb.m_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, mb.m_valid, 1);
  endtask

  // Called on a negedge with m_valid high; returns on the first low negedge.
  task automatic high_len(output int n);
    n = 0;
    while (mb.m_valid === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic poll_check(input logic exp_up, input logic exp_chg);
    int n;
    wait_rise("poll_rise", 600);
    check("poll_addr",  mb.m_addr,  5'd1);
    check("poll_write", mb.m_write, 0);
    high_len(n);
    check("poll_len",     n,        41);
    check("poll_link_up", link_up,  exp_up);
    check("poll_chg",     link_chg, exp_chg);
    @(negedge clk);
    check("poll_chg_end", link_chg, 0);
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } ivec_t;

  typedef struct {
    logic        write;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        drop;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_len;
  } hvec_t;

  initial begin
    ivec_t ivec [3];
    hvec_t hvec [8];
    int    n;

    ivec[0] = '{5'h00, 16'h8000};
    ivec[1] = '{5'h1B, 16'h0010};
    ivec[2] = '{5'h04, 16'h01E1};

    hvec[0] = '{1'b1, 5'h10, 16'h1234, 1'b0, 16'h0000, 1'b0, 41};
    hvec[1] = '{1'b0, 5'h10, 16'h0000, 1'b0, 16'h1234, 1'b0, 41};
    hvec[2] = '{1'b0, 5'h02, 16'h0000, 1'b0, 16'h0141, 1'b0, 41};
    hvec[3] = '{1'b1, 5'h05, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 41};
    hvec[4] = '{1'b0, 5'h05, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 41};
    hvec[5] = '{1'b0, 5'h07, 16'h0000, 1'b1, 16'h0000, 1'b1, 64};
    hvec[6] = '{1'b1, 5'h08, 16'h5555, 1'b1, 16'h0000, 1'b1, 64};
    hvec[7] = '{1'b0, 5'h00, 16'h0000, 1'b0, 16'h8000, 1'b0, 41};

    hb.h_valid = 1'b0;
    hb.h_write = 1'b0;
    hb.h_addr  = 5'h00;
    hb.h_wdata = 16'h0000;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();

    // Init replay: A, B, C in order, each followed by GAP then IDLE.
    reset = 1'b0;
    @(negedge clk);
    check("init_first_rise", mb.m_valid, 1);
    for (int e = 0; e < 3; e++) begin
      if (e > 0) wait_rise("init_rise", 10);
      check("init_addr",    mb.m_addr,  ivec[e].addr);
      check("init_wdata",   mb.m_wdata, ivec[e].data);
      check("init_write",   mb.m_write, 1);
      check("init_h_ready", hb.h_ready, 0);
      high_len(n);
      check("init_len",       n,         41);
      check("init_done_gap",  init_done, 0);
      check("init_gap_addr",  mb.m_addr, ivec[e].addr);
      @(negedge clk);
      if (e < 2) begin
        check("init_idle_low", mb.m_valid, 0);
        @(negedge clk);
      end
    end
    check("init_done_set", init_done, 1);
    check("init_err_clr",  init_err,  0);
    check("host_ready",    hb.h_ready, 1);

    // Link polling: rise, steady, fall, steady.
    status_val = 16'h0004;
    poll_check(1'b1, 1'b1);
    poll_check(1'b1, 1'b0);
    status_val = 16'h0000;
    poll_check(1'b0, 1'b1);
    poll_check(1'b0, 1'b0);

    // Poll wrap coinciding with a host request: the poll goes first.
    wait_rise("coll_poll_rise", 600);
    check("coll_poll_addr", mb.m_addr, 5'd1);
    repeat (199) @(negedge clk);
    hb.h_write = 1'b0;
    hb.h_addr  = 5'h02;
    hb.h_valid = 1'b1;
    check("coll_wrap_ready", hb.h_ready, 0);
    @(negedge clk);
    check("coll_poll_first", mb.m_valid, 1);
    check("coll_poll_addr2", mb.m_addr, 5'd1);
    high_len(n);
    check("coll_gap_ready", hb.h_ready, 0);
    @(negedge clk);
    check("coll_idle_ready", hb.h_ready, 1);
    @(negedge clk);
    hb.h_valid = 1'b0;
    check("coll_host_valid", mb.m_valid, 1);
    check("coll_host_addr",  mb.m_addr,  5'h02);
    high_len(n);
    check("coll_rvalid", hb.h_rvalid, 1);
    check("coll_rdata",  hb.h_rdata,  16'h0141);

    // Host transactions from the vector table.
    for (int v = 0; v < 8; v++) begin
      drop_addr  = hvec[v].drop ? {1'b0, hvec[v].addr} : 6'h3F;
      hb.h_write = hvec[v].write;
      hb.h_addr  = hvec[v].addr;
      hb.h_wdata = hvec[v].wdata;
      hb.h_valid = 1'b1;
      n = 0;
      while (hb.h_ready !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("host_accept", hb.h_ready, 1);
      @(negedge clk);
      hb.h_valid = 1'b0;
      hb.h_addr  = ~hvec[v].addr;
      hb.h_wdata = ~hvec[v].wdata;
      hb.h_write = ~hvec[v].write;
      check("host_m_valid", mb.m_valid, 1);
      check("host_m_write", mb.m_write, hvec[v].write);
      check("host_m_addr",  mb.m_addr,  hvec[v].addr);
      check("host_m_wdata", mb.m_wdata, hvec[v].wdata);
      high_len(n);
      check("host_len",      n,           hvec[v].exp_len);
      check("host_hold",     mb.m_wdata,  hvec[v].wdata);
      check("host_rvalid",   hb.h_rvalid, 1);
      check("host_rdata",    hb.h_rdata,  hvec[v].exp_rdata);
      check("host_err",      hb.h_err,    hvec[v].exp_err);
      @(negedge clk);
      check("host_rvalid_end", hb.h_rvalid, 0);
      drop_addr = 6'h3F;
    end

    // Reset in the middle of a host read, then a restarted init with B timing out.
    drop_addr  = 6'h1B;
    hb.h_write = 1'b0;
    hb.h_addr  = 5'h02;
    hb.h_valid = 1'b1;
    n = 0;
    while (hb.h_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    hb.h_valid = 1'b0;
    check("mid_valid", mb.m_valid, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);
    check("restart_rise",  mb.m_valid, 1);
    check("restart_addr",  mb.m_addr,  5'h00);
    check("restart_wdata", mb.m_wdata, 16'h8000);
    high_len(n);
    check("restart_len_a", n, 41);
    wait_rise("to_b_rise", 10);
    check("to_b_addr",    mb.m_addr, 5'h1B);
    check("to_err_before", init_err, 0);
    high_len(n);
    check("to_b_len",     n,        64);
    check("to_err_set",   init_err, 1);
    wait_rise("to_c_rise", 10);
    check("to_c_addr",    mb.m_addr, 5'h04);
    high_len(n);
    check("to_c_len",     n, 41);
    @(negedge clk);
    check("to_init_done", init_done, 1);
    check("to_err_hold",  init_err,  1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
